// File: rtl/gpio_pad_ctrl_if.sv
// gpio_pad_ctrl_if: register-file and pad-ring signals of the per-pin GPIO controller.
interface gpio_pad_ctrl_if #(
    parameter int NUM_PIN    = 8,
    parameter int DBNC_WIDTH = 8
);
    logic [NUM_PIN-1:0]    dir_i;
    logic [NUM_PIN-1:0]    out_i;
    logic [NUM_PIN-1:0]    pull_en_i;
    logic [NUM_PIN-1:0]    dbnc_en_i;
    logic [DBNC_WIDTH-1:0] dbnc_thr_i;
    logic [NUM_PIN-1:0]    irq_rise_en_i;
    logic [NUM_PIN-1:0]    irq_fall_en_i;
    logic [NUM_PIN-1:0]    irq_clr_i;
    logic [NUM_PIN-1:0]    pad_i_o;
    logic [NUM_PIN-1:0]    pad_oen_o;
    logic [NUM_PIN-1:0]    pad_ren_o;
    logic [NUM_PIN-1:0]    pad_c_i;
    logic [NUM_PIN-1:0]    in_o;
    logic [NUM_PIN-1:0]    irq_pend_o;
    logic                  irq_o;

    modport master (
        output dir_i, out_i, pull_en_i, dbnc_en_i, dbnc_thr_i,
               irq_rise_en_i, irq_fall_en_i, irq_clr_i, pad_c_i,
        input  pad_i_o, pad_oen_o, pad_ren_o, in_o, irq_pend_o, irq_o
    );

    modport slave (
        input  dir_i, out_i, pull_en_i, dbnc_en_i, dbnc_thr_i,
               irq_rise_en_i, irq_fall_en_i, irq_clr_i, pad_c_i,
        output pad_i_o, pad_oen_o, pad_ren_o, in_o, irq_pend_o, irq_o
    );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: registers pad drive controls, synchronises and debounces pad input,
// and latches filtered edges into sticky write-1-to-clear interrupt-pending bits.
module gpio_pad_ctrl #(
    parameter int NUM_PIN    = 8,
    parameter int DBNC_WIDTH = 8
) (
    input logic           clk_i,
    input logic           rst_n_i,
    gpio_pad_ctrl_if.slave bus
);
    logic [NUM_PIN-1:0]    s1, s2, filt, filt_q, pend, filt_d, rise, fall;
    logic [DBNC_WIDTH-1:0] cnt   [NUM_PIN];
    logic [DBNC_WIDTH-1:0] cnt_d [NUM_PIN];

    // filt follows s2 when bypassed or once the mismatch has outlasted the threshold
    always_comb begin
        filt_d = filt;
        for (int k = 0; k < NUM_PIN; k++) begin
            filt_d[k] = (!bus.dbnc_en_i[k] || cnt[k] >= bus.dbnc_thr_i) ? s2[k] : filt[k];
            cnt_d[k]  = (bus.dbnc_en_i[k] && s2[k] != filt[k] && cnt[k] < bus.dbnc_thr_i)
                        ? cnt[k] + 1'b1 : '0;
        end
    end

    assign rise           = filt & ~filt_q;
    assign fall           = ~filt & filt_q;
    assign bus.in_o       = filt;
    assign bus.irq_pend_o = pend;
    assign bus.irq_o      = |pend;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.pad_i_o   <= '0;
            bus.pad_oen_o <= '1;
            bus.pad_ren_o <= '0;
            s1            <= '0;
            s2            <= '0;
            filt          <= '0;
            filt_q        <= '0;
            pend          <= '0;
            for (int k = 0; k < NUM_PIN; k++) cnt[k] <= '0;
        end else begin
            bus.pad_i_o   <= bus.out_i;
            bus.pad_oen_o <= ~bus.dir_i;
            bus.pad_ren_o <= bus.pull_en_i;
            s1            <= bus.pad_c_i;
            s2            <= s1;
            filt          <= filt_d;
            filt_q        <= filt;
            pend          <= (rise & bus.irq_rise_en_i) | (fall & bus.irq_fall_en_i) |
                             (pend & ~bus.irq_clr_i);
            for (int k = 0; k < NUM_PIN; k++) cnt[k] <= cnt_d[k];
        end
    end
endmodule
